sc_fifo_vr: RTL and testbench

//  Single-clock FIFO with valid/ready handshakes on both sides and a selectable read mode.
//  - SHOW_AHEAD=1: first-word-fall-through.
//  - SHOW_AHEAD=0: classic read-request mode.
//  - Programmable almost-full/almost-empty flags.

---
 rtl/sc_fifo_vr.sv | 150 +++++++++++++++
 tb/tb_sc_fifo_vr.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_fifo_vr.sv
// Single-clock FIFO with valid/ready on both sides. SHOW_AHEAD selects a
// first-word-fall-through output stage or a registered read-request output.
module sc_fifo_vr #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4,
   parameter bit SHOW_AHEAD = 1'b1,
   parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 2,
   parameter int AE_LEVEL   = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  clear,
   input  logic                  s_valid,
   input  logic [DATA_WIDTH-1:0] s_data,
   output logic                  s_ready,
   output logic                  m_valid,
   output logic [DATA_WIDTH-1:0] m_data,
   input  logic                  m_ready,
   output logic [ADDR_WIDTH:0]   used_words,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty
);

   localparam int                DEPTH   = 1 << ADDR_WIDTH;
   localparam int                PTR_W   = ADDR_WIDTH + 1;
   localparam logic [PTR_W-1:0]  DEPTH_W = PTR_W'(DEPTH);

   typedef enum logic {
      ST_EMPTY,
      ST_VALID
   } state_e;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]      used_q, used_d;
   state_e                state_q, state_d;
   logic                  m_valid_q, m_valid_d;
   logic [DATA_WIDTH-1:0] m_data_q, m_data_d;

   logic                  push, pop, wr_en;
   logic [PTR_W-1:0]      ram_count;
   logic [DATA_WIDTH-1:0] ram_rd_data;

   // Flags decode registered state only, so s_ready has no path from m_ready.
   assign full         = (used_q == DEPTH_W);
   assign empty        = (used_q == '0);
   assign almost_full  = (used_q >= PTR_W'(AF_LEVEL));
   assign almost_empty = (used_q <= PTR_W'(AE_LEVEL));
   assign s_ready      = ~full;
   assign used_words   = used_q;
   assign m_valid      = m_valid_q;
   assign m_data       = m_data_q;

   assign ram_count   = wr_ptr_q - rd_ptr_q;
   assign ram_rd_data = mem[rd_ptr_q[ADDR_WIDTH-1:0]];

   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      used_d    = used_q;
      state_d   = state_q;
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      wr_en     = 1'b0;
      push      = s_valid & s_ready;
      pop       = SHOW_AHEAD ? (m_valid_q & m_ready) : (m_ready & ~empty);

      if (clear) begin
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         used_d    = '0;
         m_valid_d = 1'b0;
         state_d   = ST_EMPTY;
      end else begin
         if (push) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (push && !pop)      used_d = used_q + 1'b1;
         else if (!push && pop) used_d = used_q - 1'b1;

         if (SHOW_AHEAD) begin
            // ram_count excludes the word parked in the output register.
            case (state_q)
               ST_EMPTY: begin
                  if (ram_count != '0) begin
                     m_data_d  = ram_rd_data;
                     rd_ptr_d  = rd_ptr_q + 1'b1;
                     m_valid_d = 1'b1;
                     state_d   = ST_VALID;
                  end
               end
               ST_VALID: begin
                  if (pop) begin
                     if (ram_count != '0) begin
                        m_data_d = ram_rd_data;
                        rd_ptr_d = rd_ptr_q + 1'b1;
                     end else if (push) begin
                        // Bypass the incoming word so a 1-word FIFO still streams 1 word/clk.
                        m_data_d = s_data;
                        rd_ptr_d = rd_ptr_q + 1'b1;
                     end else begin
                        m_valid_d = 1'b0;
                        state_d   = ST_EMPTY;
                     end
                  end
               end
               default: state_d = ST_EMPTY;
            endcase
         end else begin
            m_valid_d = 1'b0;
            if (pop) begin
               m_data_d  = ram_rd_data;
               rd_ptr_d  = rd_ptr_q + 1'b1;
               m_valid_d = 1'b1;
            end
         end
      end
   end

   // NOTE: storage is deliberately not reset; pointers alone define which words are live.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= s_data;
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         used_q    <= '0;
         state_q   <= ST_EMPTY;
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         used_q    <= used_d;
         state_q   <= state_d;
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
      end
   end

endmodule

// File: tb/tb_sc_fifo_vr.sv
// Scoreboard bench for sc_fifo_vr: one FWFT instance and one read-request instance.
module tb_sc_fifo_vr;

   localparam int DW    = 32;
   localparam int AW    = 4;
   localparam int DEPTH = 16;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   logic          clear_a = 0, s_valid_a = 0, m_ready_a = 0;
   logic [DW-1:0] s_data_a = '0;
   logic          s_ready_a, m_valid_a, full_a, empty_a, af_a, ae_a;
   logic [DW-1:0] m_data_a;
   logic [AW:0]   used_a;

   logic          clear_b = 0, s_valid_b = 0, m_ready_b = 0;
   logic [DW-1:0] s_data_b = '0;
   logic          s_ready_b, m_valid_b, full_b, empty_b, af_b, ae_b;
   logic [DW-1:0] m_data_b;
   logic [AW:0]   used_b;

   sc_fifo_vr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SHOW_AHEAD(1'b1)) dut_a (
      .clk(clk), .reset_n(reset_n), .clear(clear_a),
      .s_valid(s_valid_a), .s_data(s_data_a), .s_ready(s_ready_a),
      .m_valid(m_valid_a), .m_data(m_data_a), .m_ready(m_ready_a),
      .used_words(used_a), .full(full_a), .empty(empty_a),
      .almost_full(af_a), .almost_empty(ae_a)
   );

   sc_fifo_vr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SHOW_AHEAD(1'b0)) dut_b (
      .clk(clk), .reset_n(reset_n), .clear(clear_b),
      .s_valid(s_valid_b), .s_data(s_data_b), .s_ready(s_ready_b),
      .m_valid(m_valid_b), .m_data(m_data_b), .m_ready(m_ready_b),
      .used_words(used_b), .full(full_b), .empty(empty_b),
      .almost_full(af_b), .almost_empty(ae_b)
   );

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] sbq_a[$];
   logic [DW-1:0] sbq_b[$];
   int            cnt_a = 0;
   int            pops_a = 0;
   bit            last_push_a;

   // One FWFT clock: model the handshake before the edge, check state after it.
   task automatic cycle_a();
      bit push_ok, pop_ok;
      logic [DW-1:0] exp;
      push_ok = s_valid_a && (cnt_a < DEPTH);
      pop_ok  = m_valid_a && m_ready_a;
      total++;
      if (s_ready_a !== (cnt_a < DEPTH)) begin
         bad++;
         $display("FAIL s_ready_a: got %b want %b", s_ready_a, (cnt_a < DEPTH));
      end
      if (push_ok) sbq_a.push_back(s_data_a);
      if (pop_ok) begin
         pops_a++;
         total++;
         if (sbq_a.size() == 0) begin
            bad++;
            $display("FAIL underflow_a: got word %h want none", m_data_a);
         end else begin
            exp = sbq_a.pop_front();
            if (m_data_a !== exp) begin
               bad++;
               $display("FAIL data_a: got %h want %h", m_data_a, exp);
            end
         end
      end
      last_push_a = push_ok;
      @(posedge clk); #1;
      cnt_a = cnt_a + int'(push_ok) - int'(pop_ok);
      total++;
      if (used_a !== (AW+1)'(cnt_a) || full_a !== (cnt_a == DEPTH) || empty_a !== (cnt_a == 0)
          || af_a !== (cnt_a >= DEPTH-2) || ae_a !== (cnt_a <= 2)) begin
         bad++;
         $display("FAIL count_a: got used=%0d f=%b e=%b af=%b ae=%b want used=%0d",
                  used_a, full_a, empty_a, af_a, ae_a, cnt_a);
      end
   endtask

   task automatic drain_a(input int max_cycles);
      s_valid_a = 0;
      m_ready_a = 1;
      for (int i = 0; i < max_cycles && cnt_a > 0; i++) cycle_a();
      m_ready_a = 0;
      total++;
      if (cnt_a != 0 || sbq_a.size() != 0) begin
         bad++;
         $display("FAIL drain_a: got cnt=%0d q=%0d want 0", cnt_a, sbq_a.size());
      end
   endtask

   task automatic check_reset_outputs(input string name);
      total++;
      if (m_valid_a !== 0 || m_data_a !== '0 || full_a !== 0 || empty_a !== 1 || af_a !== 0
          || ae_a !== 1 || used_a !== '0 || s_ready_a !== 1) begin
         bad++;
         $display("FAIL %s_a: got v=%b d=%h f=%b e=%b af=%b ae=%b u=%0d want reset values",
                  name, m_valid_a, m_data_a, full_a, empty_a, af_a, ae_a, used_a);
      end
      total++;
      if (m_valid_b !== 0 || m_data_b !== '0 || full_b !== 0 || empty_b !== 1 || af_b !== 0
          || ae_b !== 1 || used_b !== '0) begin
         bad++;
         $display("FAIL %s_b: got v=%b d=%h f=%b e=%b u=%0d want reset values",
                  name, m_valid_b, m_data_b, full_b, empty_b, used_b);
      end
   endtask

   task automatic test_reset();
      reset_n = 0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      reset_n = 1;
      #1;
      check_reset_outputs("release");
   endtask

   task automatic test_first_word();
      s_valid_a = 1; s_data_a = 32'h0000_00A5;
      cycle_a();
      s_valid_a = 0;
      total++;
      if (m_valid_a !== 0) begin
         bad++; $display("FAIL fwft_early: got m_valid=%b want 0", m_valid_a);
      end
      cycle_a();
      total++;
      if (m_valid_a !== 1 || m_data_a !== 32'hA5 || empty_a !== 0) begin
         bad++;
         $display("FAIL fwft_first: got v=%b d=%h e=%b want 1 a5 0", m_valid_a, m_data_a, empty_a);
      end
   endtask

   task automatic test_back_to_back();
      // Starts with one word in the output stage and nothing behind it.
      s_valid_a = 1; m_ready_a = 1;
      for (int i = 0; i < 6; i++) begin
         s_data_a = 32'hB000_0000 + i;
         cycle_a();
         total++;
         if (m_valid_a !== 1) begin
            bad++; $display("FAIL b2b_valid: got %b want 1 at step %0d", m_valid_a, i);
         end
      end
      s_valid_a = 0;
      cycle_a();
      m_ready_a = 0;
      total++;
      if (m_valid_a !== 0 || cnt_a != 0) begin
         bad++; $display("FAIL b2b_last: got v=%b cnt=%0d want 0 0", m_valid_a, cnt_a);
      end
   endtask

   task automatic test_fill();
      m_ready_a = 0;
      for (int i = 0; i < DEPTH + 1; i++) begin
         s_valid_a = 1; s_data_a = 32'hC0DE_0000 + i;
         cycle_a();
      end
      s_valid_a = 0;
      total++;
      if (used_a !== 5'd16 || full_a !== 1 || s_ready_a !== 0 || af_a !== 1) begin
         bad++;
         $display("FAIL fill: got u=%0d f=%b r=%b af=%b want 16 1 0 1", used_a, full_a, s_ready_a, af_a);
      end
   endtask

   task automatic test_wrap();
      int nxt = 100;
      int p0  = pops_a;
      bit first_refused;
      m_ready_a = 1;
      for (int i = 0; i < 40; i++) begin
         s_valid_a = 1; s_data_a = 32'hD000_0000 + nxt;
         cycle_a();
         if (i == 0) first_refused = !last_push_a;
         if (last_push_a) nxt++;
      end
      total++;
      if (!first_refused || pops_a - p0 != 40 || cnt_a != 15) begin
         bad++;
         $display("FAIL wrap: got refused=%b pops=%0d cnt=%0d want 1 40 15", first_refused, pops_a - p0, cnt_a);
      end
      drain_a(40);
   endtask

   task automatic test_read_request();
      for (int i = 0; i < 3; i++) begin
         s_valid_b = 1; s_data_b = 32'hE000_0000 + i;
         sbq_b.push_back(s_data_b);
         @(posedge clk); #1;
      end
      s_valid_b = 0;
      total++;
      if (used_b !== 5'd3 || m_valid_b !== 0) begin
         bad++; $display("FAIL rr_fill: got u=%0d v=%b want 3 0", used_b, m_valid_b);
      end
      for (int i = 0; i < 4; i++) begin
         m_ready_b = 1;
         @(posedge clk); #1;
         m_ready_b = 0;
         total++;
         if (i < 3) begin
            if (m_valid_b !== 1 || sbq_b.size() == 0 || m_data_b !== sbq_b[0] || used_b !== 5'(2 - i)) begin
               bad++;
               $display("FAIL rr_read: got v=%b d=%h u=%0d want 1 word %0d used %0d", m_valid_b, m_data_b, used_b, i, 2 - i);
            end
            if (sbq_b.size() != 0) void'(sbq_b.pop_front());
         end else begin
            if (m_valid_b !== 0 || m_data_b !== 32'hE000_0002 || used_b !== '0) begin
               bad++;
               $display("FAIL rr_ignored: got v=%b d=%h u=%0d want 0 e0000002 0", m_valid_b, m_data_b, used_b);
            end
         end
         @(posedge clk); #1;
         total++;
         if (m_valid_b !== 0) begin
            bad++; $display("FAIL rr_pulse: got v=%b want 0 after read %0d", m_valid_b, i);
         end
      end
   endtask

   task automatic test_clear();
      for (int i = 0; i < 8; i++) begin
         s_valid_a = 1; s_data_a = 32'hF000_0000 + i;
         cycle_a();
      end
      s_valid_a = 0;
      cycle_a();
      clear_a = 1; s_valid_a = 1; s_data_a = 32'hDEAD_BEEF; m_ready_a = 1;
      @(posedge clk); #1;
      clear_a = 0; s_valid_a = 0; m_ready_a = 0;
      sbq_a.delete();
      cnt_a = 0;
      total++;
      if (used_a !== '0 || empty_a !== 1 || m_valid_a !== 0 || m_data_a !== 32'hF000_0000) begin
         bad++;
         $display("FAIL clear: got u=%0d e=%b v=%b d=%h want 0 1 0 f0000000", used_a, empty_a, m_valid_a, m_data_a);
      end
      cycle_a();
      total++;
      if (m_valid_a !== 0) begin
         bad++; $display("FAIL clear_push: got v=%b want 0", m_valid_a);
      end
      s_valid_a = 1; s_data_a = 32'h0000_1234;
      cycle_a();
      s_valid_a = 0;
      cycle_a();
      drain_a(10);
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 5; i++) begin
         s_valid_a = 1; s_data_a = 32'h5000_0000 + i;
         cycle_a();
      end
      s_valid_a = 0;
      #2 reset_n = 0;
      #1;
      check_reset_outputs("midreset");
      sbq_a.delete();
      cnt_a = 0;
      @(posedge clk); #1;
      reset_n = 1;
      s_valid_a = 1; s_data_a = 32'h0000_0077;
      cycle_a();
      s_data_a = 32'h0000_0078;
      cycle_a();
      s_valid_a = 0;
      cycle_a();
      total++;
      if (m_valid_a !== 1 || m_data_a !== 32'h77) begin
         bad++; $display("FAIL after_reset: got v=%b d=%h want 1 77", m_valid_a, m_data_a);
      end
      drain_a(10);
   endtask

   initial begin
      test_reset();
      test_first_word();
      test_back_to_back();
      test_fill();
      test_wrap();
      test_read_request();
      test_clear();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no completion want finish before 200000");
      $fatal(1);
   end

endmodule
